// File: rtl/mic1_mem_ctrl_if.sv
// MIC-1 memory request/response bus between the datapath and mic1_mem_ctrl.
// The master issues strobes and addresses; the slave returns data and status.
interface mic1_mem_ctrl_if;
    logic        mem_read;
    logic        mem_write;
    logic        mem_fetch;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_addr_instr;
    logic [31:0] mem_rdata;
    logic [7:0]  mem_rd_instr;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output mem_read,
        output mem_write,
        output mem_fetch,
        output mem_addr,
        output mem_wdata,
        output mem_addr_instr,
        input  mem_rdata,
        input  mem_rd_instr,
        input  busy,
        input  done,
        input  err
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_fetch,
        input  mem_addr,
        input  mem_wdata,
        input  mem_addr_instr,
        output mem_rdata,
        output mem_rd_instr,
        output busy,
        output done,
        output err
    );
endinterface

// File: rtl/mic1_mem_ctrl.sv
// MIC-1 data/instruction memory controller in front of a single-port sync RAM.
// Define MIC1_FETCH_BUF_EN to add a one-word instruction fetch buffer.
module mic1_mem_ctrl #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              resetn,
    mic1_mem_ctrl_if.slave    bus,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_FETCH,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              fe_q, fe_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W+1:0] ai_q, ai_d;
    logic              cap_rd_q, cap_rd_d;
    logic              cap_fe_q, cap_fe_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic [7:0]        mem_rd_instr_q, mem_rd_instr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_wdata_q, ram_wdata_d;
    logic              any_stb;
    logic              hit;
`ifdef MIC1_FETCH_BUF_EN
    logic [31:0]       buf_data_q, buf_data_d;
    logic [ADDR_W-1:0] buf_tag_q, buf_tag_d;
    logic              buf_vld_q, buf_vld_d;
    logic              wr_inval;
`endif

    function automatic logic [7:0] sel_byte(
        input logic [31:0] w,
        input logic [1:0]  b
    );
        logic [7:0] r;
        unique case (b)
            2'd0: r = w[31:24];
            2'd1: r = w[23:16];
            2'd2: r = w[15:8];
            2'd3: r = w[7:0];
        endcase
        return r;
    endfunction

    assign any_stb = bus.mem_read | bus.mem_write | bus.mem_fetch;

    always_comb begin
        state_d        = state_q;
        rd_d           = rd_q;
        wr_d           = wr_q;
        fe_d           = fe_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        ai_d           = ai_q;
        cap_rd_d       = 1'b0;
        cap_fe_d       = 1'b0;
        ram_en_d       = 1'b0;
        ram_we_d       = 1'b0;
        ram_addr_d     = ram_addr_q;
        ram_wdata_d    = ram_wdata_q;
        err_d          = err_q | ((state_q != S_IDLE) & any_stb);
        mem_rdata_d    = cap_rd_q ? ram_rdata : mem_rdata_q;
        mem_rd_instr_d = cap_fe_q ? sel_byte(ram_rdata, ai_q[1:0])
                                  : mem_rd_instr_q;
`ifdef MIC1_FETCH_BUF_EN
        buf_data_d = buf_data_q;
        buf_tag_d  = buf_tag_q;
        buf_vld_d  = buf_vld_q;
        // A write to the buffered word must not be shadowed by a stale hit.
        wr_inval   = bus.mem_write
                   & (bus.mem_addr[ADDR_W-1:0] == buf_tag_q);
        hit        = bus.mem_fetch & buf_vld_q & ~wr_inval
                   & (bus.mem_addr_instr[ADDR_W+1:2] == buf_tag_q);
        if (cap_fe_q) begin
            buf_data_d = ram_rdata;
            buf_tag_d  = ai_q[ADDR_W+1:2];
            buf_vld_d  = 1'b1;
        end
`else
        hit = 1'b0;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (any_stb) begin
                    rd_d    = bus.mem_read & ~bus.mem_write;
                    wr_d    = bus.mem_write;
                    fe_d    = bus.mem_fetch & ~hit;
                    addr_d  = bus.mem_addr[ADDR_W-1:0];
                    wdata_d = bus.mem_wdata;
                    ai_d    = bus.mem_addr_instr[ADDR_W+1:0];
`ifdef MIC1_FETCH_BUF_EN
                    if (wr_inval) begin
                        buf_vld_d = 1'b0;
                    end
                    if (hit) begin
                        mem_rd_instr_d = sel_byte(buf_data_q,
                                                  bus.mem_addr_instr[1:0]);
                    end
`endif
                    if (bus.mem_read | bus.mem_write) begin
                        state_d = S_DATA;
                    end else if (fe_d) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_DATA: begin
                cap_rd_d = rd_q;
                state_d  = fe_q ? S_FETCH : S_WAIT;
            end
            S_FETCH: begin
                cap_fe_d = 1'b1;
                state_d  = S_WAIT;
            end
            S_WAIT: state_d = S_RESP;
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the next state.
        unique case (state_d)
            S_DATA: begin
                ram_en_d    = 1'b1;
                ram_we_d    = wr_d;
                ram_addr_d  = addr_d;
                ram_wdata_d = wdata_d;
            end
            S_FETCH: begin
                ram_en_d   = 1'b1;
                ram_addr_d = ai_d[ADDR_W+1:2];
            end
            default: ;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= S_IDLE;
            rd_q           <= 1'b0;
            wr_q           <= 1'b0;
            fe_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            ai_q           <= '0;
            cap_rd_q       <= 1'b0;
            cap_fe_q       <= 1'b0;
            mem_rdata_q    <= '0;
            mem_rd_instr_q <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            ram_en_q       <= 1'b0;
            ram_we_q       <= 1'b0;
            ram_addr_q     <= '0;
            ram_wdata_q    <= '0;
`ifdef MIC1_FETCH_BUF_EN
            buf_data_q     <= '0;
            buf_tag_q      <= '0;
            buf_vld_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            rd_q           <= rd_d;
            wr_q           <= wr_d;
            fe_q           <= fe_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            ai_q           <= ai_d;
            cap_rd_q       <= cap_rd_d;
            cap_fe_q       <= cap_fe_d;
            mem_rdata_q    <= mem_rdata_d;
            mem_rd_instr_q <= mem_rd_instr_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_q          <= err_d;
            ram_en_q       <= ram_en_d;
            ram_we_q       <= ram_we_d;
            ram_addr_q     <= ram_addr_d;
            ram_wdata_q    <= ram_wdata_d;
`ifdef MIC1_FETCH_BUF_EN
            buf_data_q     <= buf_data_d;
            buf_tag_q      <= buf_tag_d;
            buf_vld_q      <= buf_vld_d;
`endif
        end
    end

    assign bus.mem_rdata    = mem_rdata_q;
    assign bus.mem_rd_instr = mem_rd_instr_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign ram_en           = ram_en_q;
    assign ram_we           = ram_we_q;
    assign ram_addr         = ram_addr_q;
    assign ram_wdata        = ram_wdata_q;

endmodule
